// File: rtl/bsg_cgol_pkg.sv
// Shared types and sizing helpers for the CGoL board I/O blocks.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eIDLE   = 2'd0,
    eSEND   = 2'd1,
    eHEADER = 2'd2
  } oser_state_e;

  // Words needed to carry n bits at w bits per word.
  function automatic int ceil_div(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_cgol_output_serializer_if.sv
// Snapshot handoff (controller side) and narrow word stream (chip I/O side).
// master: the serializer; slave: its environment.
interface bsg_cgol_output_serializer_if #(
  parameter int board_len_p  = 8,
  parameter int word_width_p = 16
) ();
  localparam int n_lp = board_len_p * board_len_p;

  logic [n_lp-1:0]         data_i;
  logic                    v_i;
  logic                    yumi_o;
  logic [word_width_p-1:0] data_o;
  logic                    v_o;
  logic                    ready_i;
  logic                    last_o;

  modport master (
    input  data_i, v_i, ready_i,
    output yumi_o, data_o, v_o, last_o
  );

  modport slave (
    output data_i, v_i, ready_i,
    input  yumi_o, data_o, v_o, last_o
  );
endinterface

// File: rtl/bsg_cgol_oser_shift.sv
// Loadable right-shift register with zero fill; exposes its low word.
// Latency: load/shift take effect on the next clk_i edge.
// Backpressure: none here; the caller only asserts shift_i on a handshake.
module bsg_cgol_oser_shift #(
  parameter int in_width_p   = 64,
  parameter int word_width_p = 16,
  parameter int num_words_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    load_i,
  input  logic                    shift_i,
  input  logic [in_width_p-1:0]   data_i,
  output logic [word_width_p-1:0] data_o
);
  localparam int width_lp = num_words_p * word_width_p;

  logic [width_lp-1:0] buf_r;

  // Zero-extension on load gives the padded final word its zero upper bits.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   buf_r <= '0;
    else if (load_i)  buf_r <= width_lp'(data_i);
    else if (shift_i) buf_r <= buf_r >> word_width_p;
  end

  assign data_o = buf_r[word_width_p-1:0];

endmodule

// File: rtl/bsg_cgol_output_serializer.sv
// Captures a CGoL board snapshot in one cycle and streams it out LSB-first, one word per handshake.
// Latency: first word valid the cycle after yumi_o; then one word per cycle while ready_i is high.
// Backpressure: data_o/v_o/last_o hold while ready_i is low. BSG_CGOL_OSER_HEADER_EN prepends a sequence-number word.
module bsg_cgol_output_serializer
  import bsg_cgol_pkg::*;
#(
  parameter int board_len_p  = 8,
  parameter int word_width_p = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  bsg_cgol_output_serializer_if.master   io
);
  localparam int n_lp         = board_len_p * board_len_p;
  localparam int num_words_lp = ceil_div(n_lp, word_width_p);
  localparam int cnt_width_lp = safe_clog2(num_words_lp + 1);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_words_lp - 1);

  oser_state_e             state_r, state_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;
  logic                    load, shift;
  logic [word_width_p-1:0] shift_word;
`ifdef BSG_CGOL_OSER_HEADER_EN
  logic [word_width_p-1:0] seq_r, seq_n;
`endif

  bsg_cgol_oser_shift #(
    .in_width_p  (n_lp),
    .word_width_p(word_width_p),
    .num_words_p (num_words_lp)
  ) shift_reg (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (load),
    .shift_i  (shift),
    .data_i   (io.data_i),
    .data_o   (shift_word)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIDLE;
      cnt_r   <= '0;
`ifdef BSG_CGOL_OSER_HEADER_EN
      seq_r   <= '0;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
`ifdef BSG_CGOL_OSER_HEADER_EN
      seq_r   <= seq_n;
`endif
    end
  end

  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    load      = 1'b0;
    shift     = 1'b0;
    io.yumi_o = 1'b0;
    io.v_o    = 1'b0;
    io.last_o = 1'b0;
    io.data_o = shift_word;
`ifdef BSG_CGOL_OSER_HEADER_EN
    seq_n     = seq_r;
`endif
    case (state_r)
      eIDLE: begin
        // Gated by reset so yumi_o stays low while reset is asserted.
        io.yumi_o = io.v_i & reset_n_i;
        if (io.v_i) begin
          load  = 1'b1;
          cnt_n = '0;
`ifdef BSG_CGOL_OSER_HEADER_EN
          state_n = eHEADER;
`else
          state_n = eSEND;
`endif
        end
      end
      eSEND: begin
        io.v_o    = 1'b1;
        io.last_o = (cnt_r == last_cnt_lp);
        if (io.ready_i) begin
          shift = 1'b1;
          if (cnt_r == last_cnt_lp) begin
            cnt_n   = '0;
            state_n = eIDLE;
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end
      end
`ifdef BSG_CGOL_OSER_HEADER_EN
      eHEADER: begin
        io.v_o    = 1'b1;
        io.data_o = seq_r;
        if (io.ready_i) begin
          seq_n   = seq_r + 1'b1;
          state_n = eSEND;
        end
      end
`endif
      default: state_n = eIDLE;
    endcase
  end

endmodule

// File: tb/tb_bsg_cgol_output_serializer.sv
// Scoreboard bench: two serializers (4x4 board at 8-bit words, and at 6-bit words with padding).
module tb_bsg_cgol_output_serializer;

  localparam int NW_A = (16 + 7) / 8;
  localparam int NW_B = (16 + 5) / 6;

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
`ifdef BSG_CGOL_OSER_HEADER_EN
  logic [7:0] seq_a = '0;
  logic [5:0] seq_b = '0;
`endif

  always #5 clk = ~clk;

  bsg_cgol_output_serializer_if #(.board_len_p(4), .word_width_p(8)) ifa ();
  bsg_cgol_output_serializer_if #(.board_len_p(4), .word_width_p(6)) ifb ();

  bsg_cgol_output_serializer #(.board_len_p(4), .word_width_p(8)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .io(ifa.master));
  bsg_cgol_output_serializer #(.board_len_p(4), .word_width_p(6)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .io(ifb.master));

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Reference: an accepted board becomes ceil(16/W) words, word k = board bits [k*W +: W], zero beyond bit 15.
  task automatic mon_a();
    logic       busy;
    logic [31:0] s;
    exp_t       e;
    busy = (qa.size() != 0);
    chk("a_v_o", 16'(ifa.v_o), 16'(busy));
    chk("a_yumi_o", 16'(ifa.yumi_o), 16'(ifa.v_i & ~busy));
    if (busy) begin
      e = qa[0];
      chk("a_data_o", 16'(ifa.data_o), 16'(e.dat));
      chk("a_last_o", 16'(ifa.last_o), 16'(e.last));
      if (ifa.ready_i) void'(qa.pop_front());
    end else begin
      chk("a_last_idle", 16'(ifa.last_o), 16'd0);
      if (ifa.v_i) begin
        s = 32'(ifa.data_i);
`ifdef BSG_CGOL_OSER_HEADER_EN
        e.dat = seq_a; e.last = 1'b0; qa.push_back(e); seq_a = seq_a + 8'd1;
`endif
        for (int k = 0; k < NW_A; k++) begin
          e.dat  = 8'((s >> (8 * k)) & 32'hFF);
          e.last = (k == NW_A - 1);
          qa.push_back(e);
        end
      end
    end
  endtask

  task automatic mon_b();
    logic       busy;
    logic [31:0] s;
    exp_t       e;
    busy = (qb.size() != 0);
    chk("b_v_o", 16'(ifb.v_o), 16'(busy));
    chk("b_yumi_o", 16'(ifb.yumi_o), 16'(ifb.v_i & ~busy));
    if (busy) begin
      e = qb[0];
      chk("b_data_o", 16'(ifb.data_o), 16'(e.dat));
      chk("b_last_o", 16'(ifb.last_o), 16'(e.last));
      if (ifb.ready_i) void'(qb.pop_front());
    end else begin
      chk("b_last_idle", 16'(ifb.last_o), 16'd0);
      if (ifb.v_i) begin
        s = 32'(ifb.data_i);
`ifdef BSG_CGOL_OSER_HEADER_EN
        e.dat = {2'b00, seq_b}; e.last = 1'b0; qb.push_back(e); seq_b = seq_b + 6'd1;
`endif
        for (int k = 0; k < NW_B; k++) begin
          e.dat  = 8'((s >> (6 * k)) & 32'h3F);
          e.last = (k == NW_B - 1);
          qb.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!in_rst) begin
      mon_a();
      mon_b();
    end
  end

  task automatic drive(input logic va, input logic vb, input logic ra, input logic rb,
                       input logic [15:0] da, input logic [15:0] db);
    @(posedge clk);
    #1;
    ifa.v_i = va; ifa.ready_i = ra; ifa.data_i = da;
    ifb.v_i = vb; ifb.ready_i = rb; ifb.data_i = db;
  endtask

  task automatic chk_reset_outputs();
    chk("a_rst_v_o", 16'(ifa.v_o), 16'd0);
    chk("a_rst_yumi_o", 16'(ifa.yumi_o), 16'd0);
    chk("a_rst_last_o", 16'(ifa.last_o), 16'd0);
    chk("a_rst_data_o", 16'(ifa.data_o), 16'd0);
    chk("b_rst_v_o", 16'(ifb.v_o), 16'd0);
    chk("b_rst_yumi_o", 16'(ifb.yumi_o), 16'd0);
    chk("b_rst_last_o", 16'(ifb.last_o), 16'd0);
    chk("b_rst_data_o", 16'(ifb.data_o), 16'd0);
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            16'($urandom), 16'($urandom));
  endtask

  initial begin
    ifa.v_i = 1'b0; ifa.ready_i = 1'b0; ifa.data_i = '0;
    ifb.v_i = 1'b1; ifb.ready_i = 1'b0; ifb.data_i = '0;
    #3;
    chk_reset_outputs();
    ifb.v_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    in_rst = 1'b0;

    // Directed: known boards, a 3-cycle stall on word 1, v_i held for 10 cycles.
    for (int c = 0; c < 30; c++) begin
      if (c == 0)
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hA5C3, 16'hFFFF);
      else if (c < 10)
        drive(1'b0, 1'b0, !(c >= 2 && c <= 4), 1'b1, 16'h0, 16'h0);
      else if (c < 20)
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
      else
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    end

    // Long random run; covers sequence-number wrap in the header build.
    random_cycles(2500);

    // Reset between clock edges while word 1 is on the bus.
    for (int c = 0; c < 12; c++) drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);
    #1;
    in_rst = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk_reset_outputs();
    ifa.v_i = 1'b0; ifb.v_i = 1'b0;
    qa.delete(); qb.delete();
`ifdef BSG_CGOL_OSER_HEADER_EN
    seq_a = '0; seq_b = '0;
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    in_rst = 1'b0;

    random_cycles(300);
    for (int c = 0; c < 20; c++) drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    chk("a_drained", 16'(qa.size()), 16'd0);
    chk("b_drained", 16'(qb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
